i2s_tx_serializer: RTL and testbench
====================================

Name: i2s_tx_serializer

Overview:
- Downstream consumer of the 32-bit transmit FIFO in the I2S transceiver.
- Pops one audio word per channel from the FIFO and shifts it out as standard Philips I2S: bit clock SCK, word select WS, serial data SD.
- Runs entirely in the FIFO read-clock domain and acts as the I2S bus master.

Parameters:
- CLK_DIV, 4, clk cycles per SCK half-period; legal values ≥2.
- WORD_LEN, 32, bits sent per channel; legal range 8..32; each word is taken MSB-aligned from bits [31:32-WORD_LEN].

Ports:
- clk  in  1  system/FIFO read clock; all logic on posedge.
- Rst_n  in  1  asynchronous active-low reset.
- EN  in  1  transmit enable.
- fifo_data  in  32  FIFO dataOut; valid on the clk edge after fifo_rd.
- fifo_empty  in  1  FIFO EMPTY flag.
- fifo_rd  out  1  one-clk pop strobe to FIFO RD.
- sck  out  1  I2S bit clock.
- ws  out  1  word select; 0 = left, 1 = right.
- sd  out  1  serial data, MSB first.
- underrun  out  1  sticky flag: a pop was needed while FIFO was empty.
- underrun_clr  in  1  clears underrun (set has priority on the same cycle).
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: sck=0, ws=1, sd=0, fifo_rd=0, underrun=0, busy=0. All counters and shift/shadow registers cleared; state=IDLE.
- SCK generation:
  - div_cnt counts 0..CLK_DIV-1 and toggles sck at terminal count.
  - "fall" = a cycle in which sck goes 1→0.
  - ws and sd update only on fall; the receiver samples on rise.
- IDLE:
  - sck held at 0, div_cnt held at 0, ws=1, sd=0.
  - EN=1 → assert fifo_rd for 1 clk (or take the underrun path), then go to LEAD.
- Fetch rule (all states):
  - Each pop: fifo_rd high exactly 1 clk, and only if fifo_empty=0.
  - Next clk: shadow <= fifo_data.
  - If fifo_empty=1 at pop time: no fifo_rd, shadow <= 0, underrun <= 1.
- LEAD:
  - The divider runs.
  - First fall: ws<=0, sd<=0 (dummy bit), shift <= shadow, bit_cnt<=0, go to RUN.
- RUN (per channel, bit_cnt 0..WORD_LEN-1):
  - Each fall drives sd <= shift[31], then shift <<= 1.
  - On the fall that drives bit WORD_LEN-1 (the LSB):
    - ws toggles.
    - Next-word fetch is issued in the same cycle.
  - On the next fall: shift <= shadow, then its MSB is driven on that fall. This gives I2S one-SCK data delay after the WS edge.
  - Timing: the shadow load completes ≥2·CLK_DIV−2 clk before it is used.
- Channel order: FIFO words alternate left, right, left…; the first word after EN is left.
  - An underrun substitutes zeros but keeps the channel alignment.
- EN deasserted mid-frame:
  - The current stereo frame completes; no left-word fetch is issued at the right-LSB fall.
  - On the following fall: ws=1, sd=0, go to IDLE. sck stays low.
  - EN reasserted before then keeps RUN uninterrupted.
- Rst_n low at any time: immediate return to reset values; no partial pop is issued afterward.
- underrun:
  - underrun_clr clears it.
  - A simultaneous new underrun keeps it set.

Optional Feature:
- Macro I2S_TX_MONO_DUP_EN.
- Defined:
  - One FIFO pop per stereo frame, issued at the right-channel LSB fall only.
  - The same word is sent on left and right.
  - No pop at the left LSB; shift reloads from the unchanged shadow.
- Undefined: one pop per channel as described above.

Test Plan:
- Reset/idle: Rst_n=0 then 1 with EN=0 → sck=0, ws=1, sd=0, fifo_rd never asserted over 100 clk.
- Basic stereo (CLK_DIV=4, WORD_LEN=32): FIFO holds 0xA5A5_0001, 0x8000_00FF → ws falls, 1 SCK later sd = bits of 0xA5A5_0001 MSB-first; after 32 bits ws rises and 0x8000_00FF is shifted out. SCK period = 8 clk.
- Short word (WORD_LEN=16): word 0x1234_FFFF → only 0x1234 sent; ws toggles every 16 SCK.
- Underrun: FIFO holds one word, EN held → left = word, right = 32 zeros, underrun=1, no fifo_rd while empty. underrun_clr pulse → underrun=0.
- Stop mid-frame: drop EN during the left-channel bit 5 → right word still fully sent, then ws=1, busy=0, exactly 2 pops total.
- I2S_TX_MONO_DUP_EN: FIFO holds 0xDEAD_BEEF, 0x0BAD_F00D → frames 1 and 2 send each word on both channels; 2 pops across 2 frames.

Source files
------------

// File: rtl/i2s_tx_serializer_if.sv
// FIFO read port and Philips I2S bus of the transmit serializer.
interface i2s_tx_serializer_if;
  logic [31:0] fifo_data;
  logic        fifo_empty;
  logic        fifo_rd;
  logic        sck;
  logic        ws;
  logic        sd;

  modport master (input fifo_data, fifo_empty, output fifo_rd, sck, ws, sd);
  modport slave  (output fifo_data, fifo_empty, input fifo_rd, sck, ws, sd);
endinterface

// File: rtl/i2s_tx_serializer.sv
// I2S bus-master transmitter: pops FIFO words and shifts them out MSB-first with one-SCK data delay.
// Optional I2S_TX_MONO_DUP_EN: one pop per stereo frame, same word sent on both channels.
module i2s_tx_serializer #(
  parameter int CLK_DIV  = 4,
  parameter int WORD_LEN = 32
) (
  input  logic                       clk,
  input  logic                       Rst_n,
  input  logic                       EN,
  input  logic                       underrun_clr,
  output logic                       underrun,
  output logic                       busy,
  i2s_tx_serializer_if.master        bus
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [1:0] {IDLE, LEAD, RUN} state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic          sck_q, sck_d;
  logic          ws_q, ws_d;
  logic          sd_q, sd_d;
  logic [4:0]    bit_cnt_q, bit_cnt_d;
  logic [31:0]   shift_q, shift_d;
  logic [31:0]   shadow_q, shadow_d;
  logic          reload_q, reload_d;
  logic          pend_q, pend_d;
  logic          rd_q, rd_d;
  logic          ld_q, ld_d;
  logic          zero_q, zero_d;
  logic          underrun_q, underrun_d;

  logic          tick, fall, lsb, do_fetch, ur_set, fetch_ok;
  logic [31:0]   src;

  always_comb begin
    state_d   = state_q;
    div_cnt_d = div_cnt_q;
    sck_d     = sck_q;
    ws_d      = ws_q;
    sd_d      = sd_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    reload_d  = reload_q;
    pend_d    = pend_q;
    do_fetch  = 1'b0;

    tick = (state_q != IDLE) && (div_cnt_q == DW'(CLK_DIV - 1));
    fall = tick && sck_q;
    lsb  = (bit_cnt_q == 5'(WORD_LEN - 1));
    // reload_q marks the first fall of a word: its MSB comes straight from shadow
    src  = reload_q ? shadow_q : shift_q;
    // A withheld fetch may still be issued if the word reaches shadow before the next fall
    fetch_ok = !sck_q && ((CLK_DIV > 2) || (div_cnt_q == '0));

    if (state_q != IDLE) begin
      if (tick) begin
        div_cnt_d = '0;
        sck_d     = ~sck_q;
      end else begin
        div_cnt_d = div_cnt_q + 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        div_cnt_d = '0;
        sck_d     = 1'b0;
        ws_d      = 1'b1;
        sd_d      = 1'b0;
        bit_cnt_d = '0;
        reload_d  = 1'b0;
        pend_d    = 1'b0;
        if (EN) begin
          do_fetch = 1'b1;
          state_d  = LEAD;
        end
      end

      LEAD: begin
        if (fall) begin
          ws_d      = 1'b0;
          sd_d      = 1'b0;
          shift_d   = shadow_q;
          bit_cnt_d = '0;
          reload_d  = 1'b0;
          state_d   = RUN;
        end
      end

      RUN: begin
        if (pend_q && EN && fetch_ok && !fall) begin
          do_fetch = 1'b1;
          pend_d   = 1'b0;
        end
        if (fall) begin
          if (reload_q && pend_q) begin
            state_d  = IDLE;
            ws_d     = 1'b1;
            sd_d     = 1'b0;
            pend_d   = 1'b0;
            reload_d = 1'b0;
          end else begin
            sd_d    = src[31];
            shift_d = {src[30:0], 1'b0};
            if (lsb) begin
              ws_d      = ~ws_q;
              bit_cnt_d = '0;
              reload_d  = 1'b1;
`ifdef I2S_TX_MONO_DUP_EN
              if (ws_q) begin
                if (EN) do_fetch = 1'b1;
                else    pend_d   = 1'b1;
              end
`else
              if (!ws_q || EN) do_fetch = 1'b1;
              else             pend_d   = 1'b1;
`endif
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
              reload_d  = 1'b0;
            end
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Pop pipeline: rd strobe, then the FIFO output is valid one clk later
  always_comb begin
    rd_d       = do_fetch && !bus.fifo_empty;
    ur_set     = do_fetch && bus.fifo_empty;
    zero_d     = ur_set;
    ld_d       = rd_q;
    shadow_d   = shadow_q;
    if (ld_q)   shadow_d = bus.fifo_data;
    if (zero_q) shadow_d = '0;
    underrun_d = ur_set | (underrun_q & ~underrun_clr);
  end

  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q    <= IDLE;
      div_cnt_q  <= '0;
      sck_q      <= 1'b0;
      ws_q       <= 1'b1;
      sd_q       <= 1'b0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      shadow_q   <= '0;
      reload_q   <= 1'b0;
      pend_q     <= 1'b0;
      rd_q       <= 1'b0;
      ld_q       <= 1'b0;
      zero_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_cnt_q  <= div_cnt_d;
      sck_q      <= sck_d;
      ws_q       <= ws_d;
      sd_q       <= sd_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      shadow_q   <= shadow_d;
      reload_q   <= reload_d;
      pend_q     <= pend_d;
      rd_q       <= rd_d;
      ld_q       <= ld_d;
      zero_q     <= zero_d;
      underrun_q <= underrun_d;
    end
  end

  assign bus.fifo_rd = rd_q;
  assign bus.sck     = sck_q;
  assign bus.ws      = ws_q;
  assign bus.sd      = sd_q;
  assign underrun    = underrun_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Directed bench: FIFO models and I2S receivers around a 32-bit/div-4 and a 16-bit/div-2 instance.
`timescale 1ns/1ps
module tb_i2s_tx_serializer;

`ifdef I2S_TX_MONO_DUP_EN
  localparam bit MONO = 1'b1;
`else
  localparam bit MONO = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, en_a, en_b, clr_a, clr_b;
  logic ur_a, ur_b, busy_a, busy_b;

  i2s_tx_serializer_if ifa();
  i2s_tx_serializer_if ifb();

  i2s_tx_serializer #(.CLK_DIV(4), .WORD_LEN(32)) dut_a (
    .clk(clk), .Rst_n(rst_n), .EN(en_a), .underrun_clr(clr_a),
    .underrun(ur_a), .busy(busy_a), .bus(ifa));

  i2s_tx_serializer #(.CLK_DIV(2), .WORD_LEN(16)) dut_b (
    .clk(clk), .Rst_n(rst_n), .EN(en_b), .underrun_clr(clr_b),
    .underrun(ur_b), .busy(busy_b), .bus(ifb));

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // FIFO models: dataOut registered on the rd edge
  logic [31:0] fqa[$], fqb[$];
  int pops_a = 0, pops_b = 0, rde_a = 0, rde_b = 0;

  always @(posedge clk) begin
    if (ifa.fifo_rd) begin
      if (fqa.size() == 0) rde_a <= rde_a + 1;
      else ifa.fifo_data <= fqa.pop_front();
      pops_a <= pops_a + 1;
    end
    ifa.fifo_empty <= (fqa.size() == 0);
  end

  always @(posedge clk) begin
    if (ifb.fifo_rd) begin
      if (fqb.size() == 0) rde_b <= rde_b + 1;
      else ifb.fifo_data <= fqb.pop_front();
      pops_b <= pops_b + 1;
    end
    ifb.fifo_empty <= (fqb.size() == 0);
  end

  // I2S receivers: sample on SCK rise, word starts one SCK after a WS change
  logic [31:0] rxa_w[$], rxb_w[$];
  int rxa_c[$], rxb_c[$], b_wschg[$];
  int a_nbit = 0, a_rise = 0, b_nbit = 0, b_rise = 0;
  logic a_sckp = 0, a_wsp = 1, a_col = 0, a_ch = 0;
  logic b_sckp = 0, b_wsp = 1, b_col = 0, b_ch = 0;
  logic [31:0] a_acc = 0, b_acc = 0;
  time a_tprev = 0, a_tlast = 0;

  initial forever begin
    @(posedge clk); #1;
    if (!busy_a) begin
      a_col = 0; a_wsp = 1; a_nbit = 0;
    end else if (ifa.sck && !a_sckp) begin
      a_rise++;
      a_tprev = a_tlast; a_tlast = $time;
      if (a_col) begin
        a_acc = {a_acc[30:0], ifa.sd}; a_nbit++;
        if (a_nbit == 32) begin rxa_w.push_back(a_acc); rxa_c.push_back(int'(a_ch)); a_col = 0; end
      end
      if (ifa.ws != a_wsp) begin a_col = 1; a_nbit = 0; a_acc = 0; a_ch = ifa.ws; end
      a_wsp = ifa.ws;
    end
    a_sckp = ifa.sck;
  end

  initial forever begin
    @(posedge clk); #1;
    if (!busy_b) begin
      b_col = 0; b_wsp = 1; b_nbit = 0;
    end else if (ifb.sck && !b_sckp) begin
      b_rise++;
      if (b_col) begin
        b_acc = {b_acc[30:0], ifb.sd}; b_nbit++;
        if (b_nbit == 16) begin rxb_w.push_back({16'h0, b_acc[15:0]}); rxb_c.push_back(int'(b_ch)); b_col = 0; end
      end
      if (ifb.ws != b_wsp) begin b_col = 1; b_nbit = 0; b_acc = 0; b_ch = ifb.ws; b_wschg.push_back(b_rise); end
      b_wsp = ifb.ws;
    end
    b_sckp = ifb.sck;
  end

  task automatic wait_rx_a(input int n);
    int k = 0;
    while (rxa_w.size() < n && k < 5000) begin @(negedge clk); k++; end
    chk("rx_a_count", 32'(rxa_w.size()), 32'(n));
  endtask

  task automatic wait_idle_a();
    int k = 0;
    while (busy_a && k < 5000) begin @(negedge clk); k++; end
    chk("idle_a", 32'(busy_a), 32'd0);
  endtask

  task automatic clr_pulse_a();
    @(negedge clk); clr_a = 1;
    @(negedge clk); clr_a = 0;
  endtask

  initial begin
    int ba, bb, p0, k, cb;
    rst_n = 0; en_a = 0; en_b = 0; clr_a = 0; clr_b = 0;
    repeat (3) @(negedge clk);
    chk("rst_sck", 32'(ifa.sck), 32'd0);
    chk("rst_ws", 32'(ifa.ws), 32'd1);
    chk("rst_sd", 32'(ifa.sd), 32'd0);
    chk("rst_rd", 32'(ifa.fifo_rd), 32'd0);
    rst_n = 1;

    // Idle with EN low
    repeat (100) @(negedge clk);
    chk("idle_sck", 32'(ifa.sck), 32'd0);
    chk("idle_ws", 32'(ifa.ws), 32'd1);
    chk("idle_sd", 32'(ifa.sd), 32'd0);
    chk("idle_busy", 32'(busy_a), 32'd0);
    chk("idle_ur", 32'(ur_a), 32'd0);
    chk("idle_pops", 32'(pops_a), 32'd0);

    // Basic stereo frame
    fqa.push_back(32'hA5A5_0001); fqa.push_back(32'h8000_00FF);
    repeat (2) @(negedge clk);
    ba = rxa_w.size(); p0 = pops_a; en_a = 1;
    wait_rx_a(ba + 1);
    en_a = 0;
    wait_idle_a();
    chk("basic_cnt", 32'(rxa_w.size()), 32'(ba + 2));
    chk("basic_left", rxa_w[ba], 32'hA5A5_0001);
    chk("basic_lch", 32'(rxa_c[ba]), 32'd0);
    chk("basic_right", rxa_w[ba+1], MONO ? 32'hA5A5_0001 : 32'h8000_00FF);
    chk("basic_rch", 32'(rxa_c[ba+1]), 32'd1);
    chk("basic_pops", 32'(pops_a - p0), MONO ? 32'd1 : 32'd2);
    chk("sck_period", 32'(a_tlast - a_tprev), 32'd80);
    chk("basic_ur", 32'(ur_a), 32'd0);
    chk("basic_ws", 32'(ifa.ws), 32'd1);
    fqa.delete();
    repeat (3) @(negedge clk);

    // Stop during left bit 5
    fqa.push_back(32'hC0DE_0001); fqa.push_back(32'h1234_5678);
    repeat (2) @(negedge clk);
    ba = rxa_w.size(); p0 = pops_a; en_a = 1;
    k = 0;
    while (!(a_nbit == 5 && rxa_w.size() == ba) && k < 5000) begin @(negedge clk); k++; end
    chk("stop_bit5_reached", 32'(a_nbit), 32'd5);
    en_a = 0;
    wait_idle_a();
    chk("stop_cnt", 32'(rxa_w.size()), 32'(ba + 2));
    chk("stop_left", rxa_w[ba], 32'hC0DE_0001);
    chk("stop_right", rxa_w[ba+1], MONO ? 32'hC0DE_0001 : 32'h1234_5678);
    chk("stop_pops", 32'(pops_a - p0), MONO ? 32'd1 : 32'd2);
    chk("stop_ws", 32'(ifa.ws), 32'd1);
    chk("stop_sd", 32'(ifa.sd), 32'd0);
    chk("stop_sck", 32'(ifa.sck), 32'd0);
    fqa.delete();
    repeat (3) @(negedge clk);

    // Underrun: one word only
    fqa.push_back(32'h0F0F_1234);
    repeat (2) @(negedge clk);
    ba = rxa_w.size(); p0 = pops_a; en_a = 1;
    wait_rx_a(ba + 1);
    en_a = 0;
    wait_idle_a();
    chk("ur_left", rxa_w[ba], 32'h0F0F_1234);
    chk("ur_right", rxa_w[ba+1], MONO ? 32'h0F0F_1234 : 32'h0);
    chk("ur_flag", 32'(ur_a), MONO ? 32'd0 : 32'd1);
    chk("ur_pops", 32'(pops_a - p0), 32'd1);
    chk("ur_rd_empty", 32'(rde_a), 32'd0);
    clr_pulse_a();
    @(negedge clk);
    chk("ur_cleared", 32'(ur_a), 32'd0);

    // Set wins over a simultaneous clear
    repeat (2) @(negedge clk);
    en_a = 1; clr_a = 1;
    @(negedge clk);
    chk("ur_set_prio", 32'(ur_a), 32'd1);
    en_a = 0;
    @(negedge clk);
    chk("ur_clr_after", 32'(ur_a), 32'd0);
    clr_a = 0;
    wait_idle_a();
    clr_pulse_a();

    // Two words over two frames
    fqa.push_back(32'hDEAD_BEEF); fqa.push_back(32'h0BAD_F00D);
    repeat (2) @(negedge clk);
    ba = rxa_w.size(); p0 = pops_a; en_a = 1;
    wait_rx_a(ba + 3);
    en_a = 0;
    wait_idle_a();
    chk("two_w0", rxa_w[ba],   32'hDEAD_BEEF);
    chk("two_w1", rxa_w[ba+1], MONO ? 32'hDEAD_BEEF : 32'h0BAD_F00D);
    chk("two_w2", rxa_w[ba+2], MONO ? 32'h0BAD_F00D : 32'h0);
    chk("two_w3", rxa_w[ba+3], MONO ? 32'h0BAD_F00D : 32'h0);
    chk("two_ch2", 32'(rxa_c[ba+2]), 32'd0);
    chk("two_pops", 32'(pops_a - p0), 32'd2);
    chk("two_ur", 32'(ur_a), MONO ? 32'd0 : 32'd1);
    clr_pulse_a();

    // Short words on the 16-bit instance
    fqb.push_back(32'h1234_FFFF); fqb.push_back(32'hABCD_0000);
    repeat (2) @(negedge clk);
    bb = rxb_w.size(); cb = b_wschg.size(); p0 = pops_b; en_b = 1;
    k = 0;
    while (rxb_w.size() < bb + 1 && k < 5000) begin @(negedge clk); k++; end
    en_b = 0;
    k = 0;
    while (busy_b && k < 5000) begin @(negedge clk); k++; end
    chk("short_idle", 32'(busy_b), 32'd0);
    chk("short_cnt", 32'(rxb_w.size()), 32'(bb + 2));
    chk("short_left", rxb_w[bb], 32'h0000_1234);
    chk("short_right", rxb_w[bb+1], MONO ? 32'h0000_1234 : 32'h0000_ABCD);
    chk("short_ws_period", 32'(b_wschg[cb+1] - b_wschg[cb]), 32'd16);
    chk("short_pops", 32'(pops_b - p0), MONO ? 32'd1 : 32'd2);
    chk("short_ur", 32'(ur_b), 32'd0);

    // Reset in mid-frame
    fqa.push_back(32'h5555_AAAA);
    repeat (2) @(negedge clk);
    p0 = pops_a; en_a = 1;
    repeat (100) @(negedge clk);
    rst_n = 0; en_a = 0;
    #1;
    chk("mrst_busy", 32'(busy_a), 32'd0);
    chk("mrst_ws", 32'(ifa.ws), 32'd1);
    chk("mrst_sck", 32'(ifa.sck), 32'd0);
    repeat (5) @(negedge clk);
    rst_n = 1;
    repeat (50) @(negedge clk);
    chk("mrst_pops", 32'(pops_a - p0), 32'd1);
    chk("mrst_rd", 32'(ifa.fifo_rd), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
